cfu_cmd_issuer: RTL
===================

Name: cfu_cmd_issuer

Overview:
- Initiator (master) end of the CFU cmd/rsp protocol: drives function_id and two operands into a CFU and collects its 32-bit response.
- Lets hardware (DMA, a sequencer, an accelerator front-end) run CFU operations without the CPU.
- Host side has a buffered command push port and a buffered result pop port.
- Exactly one CFU transaction in flight at a time.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RSP_DEPTH, 4, result FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  host command valid
- in_ready  out  1  command FIFO not full
- in_function_id  in  10  CFU function id
- in_op0  in  32  operand 0
- in_op1  in  32  operand 1
- out_valid  out  1  result FIFO not empty
- out_ready  in  1  host pops result
- out_data  out  32  CFU result
- out_function_id  out  10  function id of that result
- out_error  out  1  result is a timeout marker (0 when feature absent)
- cmd_valid  out  1  to CFU
- cmd_ready  in  1  from CFU
- cmd_payload_function_id  out  10
- cmd_payload_inputs_0  out  32
- cmd_payload_inputs_1  out  32
- rsp_valid  in  1  from CFU
- rsp_ready  out  1  to CFU
- rsp_payload_outputs_0  in  32
- busy  out  1  FSM not IDLE or command FIFO non-empty
- done_count  out  16  responses accepted since reset, wraps at 0xFFFF->0

Behaviour:
- Reset (async, active-high), all outputs: cmd_valid=0, rsp_ready=0, in_ready=0 while reset asserted then 1, out_valid=0, busy=0, done_count=0, payloads=0. FIFOs emptied, FSM=IDLE. Reset mid-transaction discards the in-flight command and all buffered entries.
- FIFOs:
  - Command push when in_valid&&in_ready. Result pop when out_valid&&out_ready.
  - out_* are registered from the FIFO head.
  - Simultaneous push and pop on a full or empty FIFO are both legal; occupancy is unchanged when both fire.
- FSM:
  - IDLE: if command FIFO non-empty and result FIFO has at least one free slot (occupancy < RSP_DEPTH), pop the head into the payload registers, go to ISSUE next cycle. The result slot is reserved, so a response can never be dropped.
  - ISSUE: cmd_valid=1. Payload is held stable until cmd_ready. When cmd_valid&&cmd_ready, go to WAIT_RSP. Zero-latency case: if rsp_valid is also 1 in that cycle, accept the response and go straight to IDLE.
  - WAIT_RSP: cmd_valid=0, rsp_ready=1. When rsp_valid, push {function_id, outputs_0, error=0} into the result FIFO, increment done_count, go to IDLE.
- rsp_ready = (ISSUE && cmd_ready) || WAIT_RSP. rsp_valid at any other time is ignored (not accepted).
- Throughput: at most one transaction per 3 cycles (IDLE->ISSUE->WAIT_RSP), 2 cycles in the zero-latency case.
- Result FIFO full: IDLE stalls and cmd_valid stays 0 until a pop frees a slot. A pop and the IDLE check in the same cycle use the pre-pop occupancy, so the stall lasts one extra cycle.
- Command FIFO full: in_ready=0. Pushes are lost only if the host violates the handshake.

Optional Feature:
- Macro: CFU_CMD_ISSUER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_RSP. When it reaches TIMEOUT_CYCLES, push {function_id, 32'h0, error=1}, increment done_count, and enter DRAIN.
  - DRAIN holds rsp_ready=1, accepts and discards exactly one late response, then returns to IDLE. Reset clears DRAIN.
- Undefined: no watchdog and no DRAIN state. WAIT_RSP waits indefinitely. out_error is tied to 0.

Test Plan:
- Single op: push (0x007, 5, 3); bench CFU model responds op0+op1 after 2 cycles -> cmd payload matches exactly; out_data=8, out_function_id=0x007, out_error=0, done_count=1.
- Back-pressure: cmd_ready held 0 for 3 cycles on (0x00F, 5, 3) -> cmd_valid and payload stable all 3 cycles, exactly one handshake; model result 2 delivered.
- Zero-latency CFU: rsp_valid asserted in the same cycle as cmd_ready for (0x017, 5, 3), model returns 15 -> accepted in the handshake cycle, out_data=15, next command issued 2 cycles later.
- Result FIFO full: out_ready=0, push 6 commands (RSP_DEPTH=4) -> exactly 4 CFU handshakes, then cmd_valid stays 0. Pop one -> the 5th issues. In-order results; done_count reaches 6 after draining.
- Reset mid-transaction: assert reset while in WAIT_RSP with 2 queued commands -> all outputs return to reset values immediately; after release, no cmd_valid until a new push.
- Timeout (macro defined, TIMEOUT_CYCLES=8): model never responds -> after 8 cycles the result has out_error=1, data 0; a late rsp_valid is accepted and discarded; the next command (5, 3 -> 8) completes normally.

Source files
------------

// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: initiator end of the CFU cmd/rsp protocol.
// Host commands are buffered in a command FIFO. Each command is issued to the CFU
// one at a time, and its 32-bit response is buffered in a result FIFO.
// A result slot is reserved before a command is issued, so a response is never dropped.
// Optional response watchdog with DRAIN state: define CFU_CMD_ISSUER_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
// A valid signal holds its payload stable until that edge.
module cfu_cmd_issuer #(
   parameter int CMD_DEPTH      = 4,
   parameter int RSP_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [9:0]  in_function_id,
   input  logic [31:0] in_op0,
   input  logic [31:0] in_op1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [9:0]  out_function_id,
   output logic        out_error,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [9:0]  cmd_payload_function_id,
   output logic [31:0] cmd_payload_inputs_0,
   output logic [31:0] cmd_payload_inputs_1,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_payload_outputs_0,
   output logic        busy,
   output logic [15:0] done_count,
   output logic [1:0]  dbg_state
);

   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam int CW  = 74;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
   localparam int RW  = 43;
   localparam int WW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] S_DRAIN = 2'd3;
`else
   localparam int RW  = 42;
`endif
   localparam logic [CAW:0] CMD_FULL = (CAW + 1)'(CMD_DEPTH);
   localparam logic [RAW:0] RSP_FULL = (RAW + 1)'(RSP_DEPTH);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_RSP = 2'd2;

   // Reject illegal depths or watchdog limits at elaboration time
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
       RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("cfu_cmd_issuer: illegal parameter values");
   end

   logic [CW-1:0]  cmd_mem_q [CMD_DEPTH];
   logic [CAW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
   logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
   logic [RW-1:0]  rsp_mem_q [RSP_DEPTH];
   logic [RAW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
   logic [RAW:0]   rsp_cnt_q, rsp_cnt_d;
   logic [1:0]     state_q, state_d;
   logic [9:0]     func_q, func_d;
   logic [31:0]    op0_q, op0_d, op1_q, op1_d;
   logic [15:0]    done_q, done_d;
   logic           cmd_push, cmd_pop, rsp_push, rsp_pop;
   logic [31:0]    rsp_data;
   logic [CW-1:0]  cmd_head;
   logic [RW-1:0]  rsp_head, rsp_entry;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
   logic [WW-1:0]  wdog_q, wdog_d;
   logic           rsp_err;
`endif

   // Host-facing status, FIFO heads and registered payload outputs
   always_comb begin
      in_ready                = !reset && (cmd_cnt_q != CMD_FULL);
      out_valid               = (rsp_cnt_q != '0);
      cmd_head                = cmd_mem_q[cmd_rd_q];
      rsp_head                = rsp_mem_q[rsp_rd_q];
      out_data                = rsp_head[31:0];
      out_function_id         = rsp_head[41:32];
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
      out_error               = rsp_head[42];
      rsp_entry               = {rsp_err, func_q, rsp_data};
`else
      out_error               = 1'b0;
      rsp_entry               = {func_q, rsp_data};
`endif
      cmd_payload_function_id = func_q;
      cmd_payload_inputs_0    = op0_q;
      cmd_payload_inputs_1    = op1_q;
      busy                    = (state_q != S_IDLE) || (cmd_cnt_q != '0);
      done_count              = done_q;
      dbg_state               = state_q;
   end

   // FIFO pointer and occupancy bookkeeping
   always_comb begin
      cmd_push  = in_valid && in_ready;
      rsp_pop   = out_valid && out_ready;
      cmd_wr_d  = cmd_wr_q + CAW'(cmd_push);
      cmd_rd_d  = cmd_rd_q + CAW'(cmd_pop);
      cmd_cnt_d = cmd_cnt_q + (CAW + 1)'(cmd_push) - (CAW + 1)'(cmd_pop);
      rsp_wr_d  = rsp_wr_q + RAW'(rsp_push);
      rsp_rd_d  = rsp_rd_q + RAW'(rsp_pop);
      rsp_cnt_d = rsp_cnt_q + (RAW + 1)'(rsp_push) - (RAW + 1)'(rsp_pop);
   end

   // Issue FSM: IDLE claims a result slot, ISSUE offers the command, WAIT_RSP collects
   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      op0_d     = op0_q;
      op1_d     = op1_q;
      done_d    = done_q;
      cmd_pop   = 1'b0;
      rsp_push  = 1'b0;
      rsp_data  = rsp_payload_outputs_0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
      wdog_d    = wdog_q;
      rsp_err   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // rsp_cnt_q is the pre-pop occupancy, so a same-cycle pop does not help yet
            if (cmd_cnt_q != '0 && rsp_cnt_q != RSP_FULL) begin
               cmd_pop = 1'b1;
               func_d  = cmd_head[73:64];
               op0_d   = cmd_head[63:32];
               op1_d   = cmd_head[31:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cmd_valid = 1'b1;
            rsp_ready = cmd_ready;
            if (cmd_ready) begin
               if (rsp_valid) begin
                  rsp_push = 1'b1;
                  done_d   = done_q + 16'd1;
                  state_d  = S_IDLE;
               end else begin
                  state_d  = S_WAIT_RSP;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
                  wdog_d   = '0;
`endif
               end
            end
         end
         S_WAIT_RSP: begin
            rsp_ready = 1'b1;
            if (rsp_valid) begin
               rsp_push = 1'b1;
               done_d   = done_q + 16'd1;
               state_d  = S_IDLE;
            end
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
            else if (wdog_q == WD_LAST) begin
               rsp_push = 1'b1;
               rsp_err  = 1'b1;
               rsp_data = 32'h0;
               done_d   = done_q + 16'd1;
               state_d  = S_DRAIN;
            end else begin
               wdog_d   = wdog_q + WW'(1);
            end
`endif
         end
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
         S_DRAIN: begin
            // Swallow exactly one late response from the timed-out command
            rsp_ready = 1'b1;
            if (rsp_valid) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO storage; validity is tracked by the reset pointers, so no reset here
   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem_q[cmd_wr_q] <= {in_function_id, in_op0, in_op1};
      if (rsp_push) rsp_mem_q[rsp_wr_q] <= rsp_entry;
   end

   // State registers; reset discards the in-flight command and all buffered entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_wr_q  <= '0;
         cmd_rd_q  <= '0;
         cmd_cnt_q <= '0;
         rsp_wr_q  <= '0;
         rsp_rd_q  <= '0;
         rsp_cnt_q <= '0;
         state_q   <= S_IDLE;
         func_q    <= '0;
         op0_q     <= '0;
         op1_q     <= '0;
         done_q    <= '0;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
         wdog_q    <= '0;
`endif
      end else begin
         cmd_wr_q  <= cmd_wr_d;
         cmd_rd_q  <= cmd_rd_d;
         cmd_cnt_q <= cmd_cnt_d;
         rsp_wr_q  <= rsp_wr_d;
         rsp_rd_q  <= rsp_rd_d;
         rsp_cnt_q <= rsp_cnt_d;
         state_q   <= state_d;
         func_q    <= func_d;
         op0_q     <= op0_d;
         op1_q     <= op1_d;
         done_q    <= done_d;
`ifdef CFU_CMD_ISSUER_TIMEOUT_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

endmodule
